reg_bank_sb: RTL and testbench
==============================

REG_BANK_SB -- requirements
Module: reg_bank_sb

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the register address width; depth is 2**ADDR_W.
REQ-002 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-003 Parameter ZERO_REG, default 1, SHALL hard-wire register 0 to zero when 1.
REQ-004 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when 1.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  in  1  reset; SHALL be asynchronous and active-low.
REQ-007 dira, dirb  in  ADDR_W  read addresses, ports A and B.
REQ-008 dirwrite  in  ADDR_W  write address.
REQ-009 datawrite  in  DATA_W  write data.
REQ-010 memwrite  in  1  write enable.
REQ-011 memread  in  1  read enable for both ports.
REQ-012 issue_en  in  1  mark register issue_dir as pending (producer in flight).
REQ-013 issue_dir  in  ADDR_W  register being marked pending.
REQ-014 a, b  out  DATA_W  registered read data, ports A and B.
REQ-015 stall  out  1  combinational; a requested operand is pending.
REQ-016 pend_cnt  out  ADDR_W+1  registered count of pending registers.

Function
REQ-017 A write with memwrite=1 SHALL update register dirwrite with datawrite at the clock edge; a write to register 0 SHALL be discarded when ZERO_REG=1.
REQ-018 With memread=1, a and b SHALL load the contents of dira and dirb at the clock edge (1-cycle latency); with memread=0, a and b SHALL hold their value.
REQ-019 With BYPASS=1, memwrite=1, memread=1 and dirwrite==dira (or dirb), the matching output SHALL load datawrite rather than the stale content; with BYPASS=0 it SHALL load the old content.
REQ-020 Reading register 0 with ZERO_REG=1 SHALL always return 0, including when bypass conditions match.
REQ-021 Scoreboard: one pending bit per register; issue_en=1 SHALL set pend[issue_dir]; memwrite=1 SHALL clear pend[dirwrite].
REQ-022 Simultaneous issue_en and memwrite to the same register SHALL leave the bit set (new producer wins).
REQ-023 pend[0] SHALL never be set when ZERO_REG=1.
REQ-024 stall SHALL be 1 when memread=1 and pend[dira] or pend[dirb] is set, except that an operand being written this cycle with BYPASS=1 SHALL not contribute.
REQ-025 stall SHALL be 0 whenever memread=0; stall SHALL not block writes or issues internally.
REQ-026 pend_cnt SHALL equal the number of set pending bits after each edge, range 0..2**ADDR_W, with no wrap.
REQ-027 Re-issuing an already pending register SHALL not change pend_cnt; clearing a non-pending register SHALL not change pend_cnt.

Reset
REQ-028 rst_n=0 SHALL immediately clear all registers, all pending bits, a, b and pend_cnt to 0, independent of clk.
REQ-029 Writes, issues and reads presented while rst_n=0 SHALL be ignored; operation SHALL resume at the first rising edge after rst_n returns to 1.
REQ-030 Assertion of reset mid-operation SHALL discard all pending state; stall SHALL be 0 after reset.

Verification
REQ-031 Write 54 to reg 5, next cycle memread with dira=5 -> a=54 one cycle later; dirb=0 -> b=0.
REQ-032 Same cycle memwrite dirwrite=8 datawrite=4, memread dira=8 -> a=4 with BYPASS=1, a=old value (0) with BYPASS=0.
REQ-033 Write 0xFFFF to reg 0, read dira=0 -> a=0; issue_en issue_dir=0 -> pend_cnt stays 0, stall=0.
REQ-034 issue reg 3, then memread dira=3 -> stall=1, pend_cnt=1; memwrite reg 3 value 7 with memread dira=3 same cycle -> stall=0, a=7, pend_cnt=0.
REQ-035 Issue regs 1..31 over successive cycles -> pend_cnt=31; issue and write reg 2 same cycle -> pend_cnt unchanged, pend[2]=1.
REQ-036 Write regs 5 and 8, issue reg 9, assert rst_n=0 between edges -> a, b, pend_cnt=0 immediately; after release, reading reg 5 -> 0.

Source files
------------

// File: rtl/reg_bank_sb.sv
// -----------------------------------------------------------------------------
// reg_bank_sb
//
// Register bank with two registered read ports, one write port, optional
// write-to-read forwarding and a per-register pending-bit scoreboard.
//
// A register is marked pending when a producer is issued for it (issue_en).
// It stops being pending when that producer's result is written back
// (memwrite). The stall output tells the consumer that an operand it is
// asking for (memread) is still waiting for its producer.
//
// Parameters
//   ADDR_W   : register address width, depth = 2**ADDR_W
//   DATA_W   : register data width
//   ZERO_REG : 1 -> register 0 reads as zero, ignores writes, is never pending
//   BYPASS   : 1 -> a write in the same cycle forwards to a matching read
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   dira, dirb in   read addresses, ports A and B
//   dirwrite   in   write address
//   datawrite  in   write data
//   memwrite   in   write enable (also clears pend[dirwrite])
//   memread    in   read enable for both ports
//   issue_en   in   set pend[issue_dir]
//   issue_dir  in   register being marked pending
//   a, b       out  registered read data, one-cycle latency, hold when idle
//   stall      out  combinational, a requested operand is still pending
//   pend_cnt   out  registered number of pending registers
// -----------------------------------------------------------------------------
module reg_bank_sb #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] dira,
    input  logic [ADDR_W-1:0] dirb,
    input  logic [ADDR_W-1:0] dirwrite,
    input  logic [DATA_W-1:0] datawrite,
    input  logic              memwrite,
    input  logic              memread,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dir,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              stall,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_next;
    logic [ADDR_W:0]   cnt_next;

    logic              zero_a;
    logic              zero_b;
    logic              fwd_a;
    logic              fwd_b;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // -------------------------------------------------------------------------
    // Address decode shared by the read path and the stall logic
    // -------------------------------------------------------------------------
    always_comb begin
        zero_a = (ZERO_REG != 0) && (dira == '0);
        zero_b = (ZERO_REG != 0) && (dirb == '0);
        // Forwarding only applies to a live write whose address matches.
        fwd_a  = (BYPASS != 0) && memwrite && (dirwrite == dira);
        fwd_b  = (BYPASS != 0) && memwrite && (dirwrite == dirb);
        // Writes to the hard-wired zero register are dropped.
        wr_ok  = memwrite && !((ZERO_REG != 0) && (dirwrite == '0));
    end

    // -------------------------------------------------------------------------
    // Read data selection. The zero-register check sits ahead of forwarding
    // so that a write to register 0 can never leak through the bypass.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_a = mem[dira];
        if (zero_a) begin
            rd_a = '0;
        end else if (fwd_a) begin
            rd_a = datawrite;
        end
    end

    always_comb begin
        rd_b = mem[dirb];
        if (zero_b) begin
            rd_b = '0;
        end else if (fwd_b) begin
            rd_b = datawrite;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard next state. The clear is applied before the set so that an
    // issue and a write-back to the same register leave it pending: the new
    // producer supersedes the one being retired.
    // -------------------------------------------------------------------------
    always_comb begin
        pend_next = pend;
        if (memwrite) begin
            pend_next[dirwrite] = 1'b0;
        end
        if (issue_en) begin
            pend_next[issue_dir] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pend_next[0] = 1'b0;
        end
    end

    // The count is recomputed from the next pending vector rather than being
    // incremented/decremented, so re-issues and redundant clears cannot skew it.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, pend_next[i]};
        end
    end

    // -------------------------------------------------------------------------
    // Stall: an operand stalls only while a read is requested and its register
    // is pending. An operand satisfied by forwarding this cycle does not stall.
    // -------------------------------------------------------------------------
    always_comb begin
        stall = memread && ((pend[dira] && !fwd_a) || (pend[dirb] && !fwd_b));
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[dirwrite] <= datawrite;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_next;
            pend_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= '0;
        end else if (memread) begin
            a <= rd_a;
            b <= rd_b;
        end
    end

endmodule

// File: tb/tb_reg_bank_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_sb
//
// Directed bench for reg_bank_sb. Two instances share every input: u_dut uses
// the default forwarding configuration, u_nb has forwarding disabled so the
// same stimulus shows both read behaviours side by side.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too (registered values) or just before the next edge (combinational stall).
// -----------------------------------------------------------------------------
module tb_reg_bank_sb;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] dira, dirb, dirwrite, issue_dir;
    logic [DATA_W-1:0] datawrite;
    logic              memwrite, memread, issue_en;

    logic [DATA_W-1:0] a, b, a_nb, b_nb;
    logic              stall, stall_nb;
    logic [ADDR_W:0]   pend_cnt, pend_cnt_nb;

    int checks = 0;
    int errors = 0;

    reg_bank_sb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .dira(dira), .dirb(dirb), .dirwrite(dirwrite),
        .datawrite(datawrite), .memwrite(memwrite), .memread(memread),
        .issue_en(issue_en), .issue_dir(issue_dir),
        .a(a), .b(b), .stall(stall), .pend_cnt(pend_cnt)
    );

    reg_bank_sb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .dira(dira), .dirb(dirb), .dirwrite(dirwrite),
        .datawrite(datawrite), .memwrite(memwrite), .memread(memread),
        .issue_en(issue_en), .issue_dir(issue_dir),
        .a(a_nb), .b(b_nb), .stall(stall_nb), .pend_cnt(pend_cnt_nb)
    );

    // clock: period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memwrite  = 1'b0;
        memread   = 1'b0;
        issue_en  = 1'b0;
        dira      = '0;
        dirb      = '0;
        dirwrite  = '0;
        issue_dir = '0;
        datawrite = '0;
    endtask

    initial begin
        // ---------------- reset, with activity that must be ignored ----------
        rst_n     = 1'b0;
        idle();
        memwrite  = 1'b1;
        dirwrite  = 5'd5;
        datawrite = 32'd99;
        issue_en  = 1'b1;
        issue_dir = 5'd4;
        tick();
        tick();
        chk("rst_a", a, 32'd0);
        chk("rst_b", b, 32'd0);
        chk("rst_cnt", {26'd0, pend_cnt}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        idle();
        memread = 1'b1;
        dira    = 5'd5;
        dirb    = 5'd4;
        #1;
        chk("rst_ign_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("rst_ign_a", a, 32'd0);
        chk("rst_ign_cnt", {26'd0, pend_cnt}, 32'd0);

        // ---------------- write 54 to reg 5, read back ----------------------
        idle();
        memwrite  = 1'b1;
        dirwrite  = 5'd5;
        datawrite = 32'd54;
        tick();
        idle();
        memread = 1'b1;
        dira    = 5'd5;
        dirb    = 5'd0;
        tick();
        chk("rd5_a", a, 32'd54);
        chk("rd5_b", b, 32'd0);
        idle();                      // memread=0, outputs must hold
        tick();
        chk("hold_a", a, 32'd54);

        // ---------------- same-cycle write/read of reg 8 --------------------
        idle();
        memwrite  = 1'b1;
        dirwrite  = 5'd8;
        datawrite = 32'd4;
        memread   = 1'b1;
        dira      = 5'd8;
        dirb      = 5'd5;
        tick();
        chk("byp_a", a, 32'd4);
        chk("nobyp_a", a_nb, 32'd0);
        chk("byp_b", b, 32'd54);
        idle();
        memread = 1'b1;
        dira    = 5'd8;
        tick();
        chk("rd8_nb", a_nb, 32'd4);

        // ---------------- register 0 is hard-wired --------------------------
        idle();
        memwrite  = 1'b1;
        dirwrite  = 5'd0;
        datawrite = 32'hFFFF;
        memread   = 1'b1;
        dira      = 5'd0;
        dirb      = 5'd0;
        tick();
        chk("zero_byp_a", a, 32'd0);
        chk("zero_byp_b", b, 32'd0);
        idle();
        memread = 1'b1;
        tick();
        chk("zero_rd_a", a, 32'd0);
        idle();
        issue_en  = 1'b1;
        issue_dir = 5'd0;
        memread   = 1'b1;
        #1;
        chk("zero_iss_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("zero_iss_cnt", {26'd0, pend_cnt}, 32'd0);
        idle();
        memread = 1'b1;
        #1;
        chk("zero_pend_stall", {31'd0, stall}, 32'd0);

        // ---------------- issue reg 3, stall, write-back clears -------------
        idle();
        issue_en  = 1'b1;
        issue_dir = 5'd3;
        tick();
        chk("iss3_cnt", {26'd0, pend_cnt}, 32'd1);
        idle();
        dira = 5'd3;                 // memread=0: no stall even though pending
        #1;
        chk("iss3_noread_stall", {31'd0, stall}, 32'd0);
        memread = 1'b1;
        #1;
        chk("iss3_stall", {31'd0, stall}, 32'd1);
        chk("iss3_stall_nb", {31'd0, stall_nb}, 32'd1);
        tick();
        memwrite  = 1'b1;
        dirwrite  = 5'd3;
        datawrite = 32'd7;
        #1;
        chk("wb3_stall", {31'd0, stall}, 32'd0);
        chk("wb3_stall_nb", {31'd0, stall_nb}, 32'd1);
        tick();
        chk("wb3_a", a, 32'd7);
        chk("wb3_a_nb", a_nb, 32'd0);
        chk("wb3_cnt", {26'd0, pend_cnt}, 32'd0);

        // ---------------- fill scoreboard -----------------------------------
        idle();
        issue_en = 1'b1;
        for (int i = 1; i < 32; i++) begin
            issue_dir = i[ADDR_W-1:0];
            tick();
        end
        chk("fill_cnt", {26'd0, pend_cnt}, 32'd31);
        idle();
        issue_en  = 1'b1;            // issue and write-back of reg 2 together
        issue_dir = 5'd2;
        memwrite  = 1'b1;
        dirwrite  = 5'd2;
        datawrite = 32'h22;
        tick();
        chk("iss_wb_cnt", {26'd0, pend_cnt}, 32'd31);
        idle();
        memread = 1'b1;
        dira    = 5'd2;
        #1;
        chk("iss_wb_stall", {31'd0, stall}, 32'd1);
        idle();
        issue_en  = 1'b1;            // re-issue already pending reg 7
        issue_dir = 5'd7;
        tick();
        chk("reissue_cnt", {26'd0, pend_cnt}, 32'd31);
        idle();
        memwrite  = 1'b1;            // clear of never-pending reg 0
        dirwrite  = 5'd0;
        tick();
        chk("clr_nonpend_cnt", {26'd0, pend_cnt}, 32'd31);
        idle();
        memwrite  = 1'b1;
        dirwrite  = 5'd2;
        datawrite = 32'h2;
        tick();
        chk("clr2_cnt", {26'd0, pend_cnt}, 32'd30);

        // ---------------- asynchronous reset mid-operation ------------------
        idle();
        memwrite  = 1'b1;
        dirwrite  = 5'd5;
        datawrite = 32'h55;
        issue_en  = 1'b1;
        issue_dir = 5'd9;
        tick();
        idle();
        memwrite  = 1'b1;
        dirwrite  = 5'd8;
        datawrite = 32'h88;
        memread   = 1'b1;
        dira      = 5'd5;
        dirb      = 5'd8;
        tick();
        chk("pre_rst_a", a, 32'h55);
        chk("pre_rst_b", b, 32'h88);
        idle();
        memread = 1'b1;
        dira    = 5'd9;
        #2;                          // mid-cycle, well away from either edge
        rst_n = 1'b0;
        #1;
        chk("async_a", a, 32'd0);
        chk("async_b", b, 32'd0);
        chk("async_cnt", {26'd0, pend_cnt}, 32'd0);
        chk("async_stall", {31'd0, stall}, 32'd0);
        tick();
        rst_n = 1'b1;
        dira  = 5'd5;
        dirb  = 5'd8;
        tick();
        chk("post_rst_a", a, 32'd0);
        chk("post_rst_b", b, 32'd0);
        chk("post_rst_cnt", {26'd0, pend_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
